// File: rtl/uart_tx_reg_module_if.sv
// Handshake bundle between register logic, the word-to-byte serializer and the UART byte transmitter.
interface uart_tx_reg_module_if #(
    parameter int REG_SIZE = 32
);
    logic [REG_SIZE-1:0] reg_data;
    logic                reg_valid;
    logic                reg_ready;
    logic [7:0]          tx_data;
    logic                tx_data_valid;
    logic                tx_ack;
    logic                tx_busy;
    logic                frame_done;

    modport master (
        output reg_data, reg_valid, tx_ack,
        input  reg_ready, tx_data, tx_data_valid, tx_busy, frame_done
    );

    modport slave (
        input  reg_data, reg_valid, tx_ack,
        output reg_ready, tx_data, tx_data_valid, tx_busy, frame_done
    );
endinterface

// File: rtl/uart_tx_reg_module.sv
// Serializes one REG_SIZE-bit word into bytes for the UART transmitter, MSB byte first by default.
// Define UART_TX_REG_LSB_FIRST_EN to send the LSB byte first instead.
module uart_tx_reg_module #(
    parameter int REG_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_reg_module_if.slave   bus
);
    localparam int N_BYTES = REG_SIZE / 8;
    localparam int CNT_W   = $clog2(N_BYTES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [REG_SIZE-1:0] r_shift;
    logic [CNT_W-1:0]    r_count;
    logic [7:0]          r_tx_data;
    logic                r_reg_ready;
    logic                r_tx_data_valid;
    logic                r_tx_busy;
    logic                r_frame_done;

    wire                w_accept = bus.reg_valid && r_reg_ready;
    wire [REG_SIZE-1:0] w_shift_next;
    wire [7:0]          w_first_byte;
    wire [7:0]          w_next_byte;

`ifdef UART_TX_REG_LSB_FIRST_EN
    assign w_shift_next = r_shift >> 8;
    assign w_first_byte = bus.reg_data[7:0];
    assign w_next_byte  = w_shift_next[7:0];
`else
    assign w_shift_next = r_shift << 8;
    assign w_first_byte = bus.reg_data[REG_SIZE-1 -: 8];
    assign w_next_byte  = w_shift_next[REG_SIZE-1 -: 8];
`endif

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_shift         <= '0;
            r_count         <= '0;
            r_tx_data       <= 8'h00;
            r_reg_ready     <= 1'b1;
            r_tx_data_valid <= 1'b0;
            r_tx_busy       <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift         <= bus.reg_data;
                        r_count         <= CNT_W'(N_BYTES);
                        r_tx_data       <= w_first_byte;
                        r_reg_ready     <= 1'b0;
                        r_tx_data_valid <= 1'b1;
                        r_tx_busy       <= 1'b1;
                        r_state         <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // tx_data holds until the transmitter acks it; no bubble between bytes.
                    if (bus.tx_ack) begin
                        r_count <= r_count - CNT_W'(1);
                        if (r_count > CNT_W'(1)) begin
                            r_shift   <= w_shift_next;
                            r_tx_data <= w_next_byte;
                        end else begin
                            r_tx_data_valid <= 1'b0;
                            r_frame_done    <= 1'b1;
                            r_state         <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_frame_done <= 1'b0;
                    r_tx_busy    <= 1'b0;
                    r_reg_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.reg_ready     = r_reg_ready;
    assign bus.tx_data       = r_tx_data;
    assign bus.tx_data_valid = r_tx_data_valid;
    assign bus.tx_busy       = r_tx_busy;
    assign bus.frame_done    = r_frame_done;
endmodule

// File: tb/tb_uart_tx_reg_module.sv
// Directed bench for uart_tx_reg_module (REG_SIZE=32); byte order follows UART_TX_REG_LSB_FIRST_EN.
module tb_uart_tx_reg_module;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    uart_tx_reg_module_if #(.REG_SIZE(32)) bus ();

    uart_tx_reg_module #(.REG_SIZE(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int k);
`ifdef UART_TX_REG_LSB_FIRST_EN
        return w[8*k +: 8];
`else
        return w[8*(3-k) +: 8];
`endif
    endfunction

    task automatic start_word(input logic [31:0] w);
        bus.reg_data  = w;
        bus.reg_valid = 1'b1;
        tick();
        bus.reg_valid = 1'b0;
    endtask

    // Called in cycle T0+1; returns in the cycle where reg_ready is back high.
    task automatic send_frame(input logic [31:0] w, input int delay, input string tag);
        check($sformatf("%s busy", tag), 32'(bus.tx_busy), 32'd1);
        check($sformatf("%s ready_low", tag), 32'(bus.reg_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            for (int d = 0; d < delay; d++) begin
                check($sformatf("%s hold b%0d d%0d", tag, k, d), 32'(bus.tx_data), 32'(exp_byte(w, k)));
                check($sformatf("%s hold_valid b%0d d%0d", tag, k, d), 32'(bus.tx_data_valid), 32'd1);
                check($sformatf("%s no_done b%0d d%0d", tag, k, d), 32'(bus.frame_done), 32'd0);
                tick();
            end
            check($sformatf("%s byte%0d", tag, k), 32'(bus.tx_data), 32'(exp_byte(w, k)));
            check($sformatf("%s valid%0d", tag, k), 32'(bus.tx_data_valid), 32'd1);
            check($sformatf("%s done_low%0d", tag, k), 32'(bus.frame_done), 32'd0);
            bus.tx_ack = 1'b1;
            tick();
            bus.tx_ack = 1'b0;
        end
        check($sformatf("%s frame_done", tag), 32'(bus.frame_done), 32'd1);
        check($sformatf("%s valid_off", tag), 32'(bus.tx_data_valid), 32'd0);
        check($sformatf("%s busy_done", tag), 32'(bus.tx_busy), 32'd1);
        check($sformatf("%s ready_done", tag), 32'(bus.reg_ready), 32'd0);
        tick();
        check($sformatf("%s done_pulse", tag), 32'(bus.frame_done), 32'd0);
        check($sformatf("%s ready_back", tag), 32'(bus.reg_ready), 32'd1);
        check($sformatf("%s busy_off", tag), 32'(bus.tx_busy), 32'd0);
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.reg_data  = '0;
        bus.reg_valid = 1'b0;
        bus.tx_ack    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst ready", 32'(bus.reg_ready), 32'd1);
        check("rst valid", 32'(bus.tx_data_valid), 32'd0);
        check("rst done", 32'(bus.frame_done), 32'd0);
        check("rst data", 32'(bus.tx_data), 32'h00);
        check("rst busy", 32'(bus.tx_busy), 32'd0);

        // Ack outside SEND must not disturb the idle block.
        bus.tx_ack = 1'b1;
        tick();
        bus.tx_ack = 1'b0;
        check("idle_ack valid", 32'(bus.tx_data_valid), 32'd0);
        check("idle_ack ready", 32'(bus.reg_ready), 32'd1);
        check("idle_ack busy", 32'(bus.tx_busy), 32'd0);

        start_word(32'h1234_5678);
        send_frame(32'h1234_5678, 0, "imm");

        start_word(32'h1234_5678);
        send_frame(32'h1234_5678, 3, "slow");

        // Word request arriving mid-frame is ignored until the block returns to idle.
        start_word(32'h1234_5678);
        bus.reg_data  = 32'hDEAD_BEEF;
        bus.reg_valid = 1'b1;
        send_frame(32'h1234_5678, 0, "busy_req");
        start_word(32'hDEAD_BEEF);
        send_frame(32'hDEAD_BEEF, 0, "queued");

        // Reset after the second ack aborts immediately.
        start_word(32'h1234_5678);
        check("abort byte0", 32'(bus.tx_data), 32'(exp_byte(32'h1234_5678, 0)));
        bus.tx_ack = 1'b1;
        tick();
        check("abort byte1", 32'(bus.tx_data), 32'(exp_byte(32'h1234_5678, 1)));
        tick();
        bus.tx_ack = 1'b0;
        check("abort byte2", 32'(bus.tx_data), 32'(exp_byte(32'h1234_5678, 2)));
        rst = 1'b1;
        #1;
        check("abort ready", 32'(bus.reg_ready), 32'd1);
        check("abort valid", 32'(bus.tx_data_valid), 32'd0);
        check("abort data", 32'(bus.tx_data), 32'h00);
        check("abort busy", 32'(bus.tx_busy), 32'd0);
        check("abort done", 32'(bus.frame_done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_abort done", 32'(bus.frame_done), 32'd0);
        check("post_abort valid", 32'(bus.tx_data_valid), 32'd0);
        tick();
        check("post_abort done2", 32'(bus.frame_done), 32'd0);

        start_word(32'hA5A5_A5A5);
        send_frame(32'hA5A5_A5A5, 1, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
